bcd_priority_encoder: RTL and testbench

//   Registered decimal-to-BCD encoder: converts a 10-line decimal input (lines 0..9) into its 4-bit BCD code.

---
 rtl/bcd_priority_encoder_if.sv | 38 +++
 rtl/bcd_priority_encoder.sv | 90 +++++++++
 tb/tb_bcd_priority_encoder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bcd_priority_encoder_if.sv
// ----------------------------------------------------------------------------
// bcd_priority_encoder_if
//   Bus bundle between a decimal-line source and the registered BCD encoder.
//
//   Signals:
//     i_i      10  decimal input lines, bit k = digit k (nominally one-hot)
//     i_en     1   encoder enable
//     o_y      4   registered BCD code of the selected line (0000..1001)
//     o_valid  1   registered, o_y holds an encoded digit
//     o_err    1   registered, enabled sample was zero-hot or multi-hot
//
//   Modports:
//     master  drives i_i / i_en, observes the encoder outputs
//     slave   the encoder itself
// ----------------------------------------------------------------------------
interface bcd_priority_encoder_if;
    logic [9:0] i_i;
    logic       i_en;
    logic [3:0] o_y;
    logic       o_valid;
    logic       o_err;

    modport master (
        output i_i,
        output i_en,
        input  o_y,
        input  o_valid,
        input  o_err
    );

    modport slave (
        input  i_i,
        input  i_en,
        output o_y,
        output o_valid,
        output o_err
    );
endinterface

// File: rtl/bcd_priority_encoder.sv
// ----------------------------------------------------------------------------
// bcd_priority_encoder
//   Registered decimal-to-BCD encoder. A 10-line decimal input is encoded to
//   its 4-bit BCD digit one clock after it is sampled, together with a valid
//   flag and an error flag for zero-hot / multi-hot samples.
//
//   Parameters:
//     HIGH_PRIORITY  1: highest asserted line wins on multi-hot input
//                    0: lowest asserted line wins
//
//   Ports:
//     i_clk  in   sole clock, rising edge
//     i_rst  in   synchronous, active-high reset; clears all outputs
//     bus    slave modport of bcd_priority_encoder_if
//              i_i / i_en in, o_y / o_valid / o_err out (all registered)
// ----------------------------------------------------------------------------
module bcd_priority_encoder #(
    parameter bit HIGH_PRIORITY = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    bcd_priority_encoder_if.slave       bus
);

    // Index of the highest set line; 0 when no line is set.
    function automatic logic [3:0] enc_high(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (v[k]) r = 4'(k);
        end
        return r;
    endfunction

    // Index of the lowest set line; 0 when no line is set.
    function automatic logic [3:0] enc_low(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (v[k]) r = 4'(k);
        end
        return r;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic is_multi_hot(input logic [9:0] v);
        return (v & (v - 10'd1)) != 10'd0;
    endfunction

    logic [3:0] y_nxt;
    logic       vld_nxt;
    logic       err_nxt;

    logic [3:0] y_p1;
    logic       vld_p1;
    logic       err_p1;

    always_comb begin
        y_nxt   = 4'd0;
        vld_nxt = 1'b0;
        err_nxt = 1'b0;
        if (bus.i_en) begin
            if (bus.i_i == 10'd0) begin
                err_nxt = 1'b1;
            end else begin
                y_nxt   = HIGH_PRIORITY ? enc_high(bus.i_i) : enc_low(bus.i_i);
                vld_nxt = 1'b1;
                err_nxt = is_multi_hot(bus.i_i);
            end
        end
    end

    // Stage p0 -> p1: single output register stage
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            y_p1   <= 4'd0;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            y_p1   <= y_nxt;
            vld_p1 <= vld_nxt;
            err_p1 <= err_nxt;
        end
    end

    assign bus.o_y     = y_p1;
    assign bus.o_valid = vld_p1;
    assign bus.o_err   = err_p1;

endmodule

// File: tb/tb_bcd_priority_encoder.sv
// ----------------------------------------------------------------------------
// tb_bcd_priority_encoder
//   Drives two encoder instances (highest-wins and lowest-wins) with the same
//   directed vectors. Each vector carries hand-computed expected outputs that
//   are queued when the vector is issued; a monitor pops one entry per clock
//   after the capturing edge and compares it with each instance's outputs.
// ----------------------------------------------------------------------------
module tb_bcd_priority_encoder;

    logic clk;
    logic rst;

    bcd_priority_encoder_if bus_hi ();
    bcd_priority_encoder_if bus_lo ();

    bcd_priority_encoder #(.HIGH_PRIORITY(1'b1)) dut_hi (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_hi.slave)
    );

    bcd_priority_encoder #(.HIGH_PRIORITY(1'b0)) dut_lo (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_lo.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected entry packing: {o_y[3:0], o_valid, o_err}
    logic [5:0] q_hi [$];
    logic [5:0] q_lo [$];

    int tests;
    int fails;

    // Monitor: outputs are presented every clock; check one #1 after each edge.
    always @(posedge clk) begin
        logic [5:0] exp_v;
        logic [5:0] act_v;
        #1;
        if (q_hi.size() > 0) begin
            exp_v = q_hi.pop_front();
            act_v = {bus_hi.o_y, bus_hi.o_valid, bus_hi.o_err};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL hi_out t=%0t: got y=%b v=%b e=%b, expected y=%b v=%b e=%b",
                         $time, act_v[5:2], act_v[1], act_v[0], exp_v[5:2], exp_v[1], exp_v[0]);
            end
        end
        if (q_lo.size() > 0) begin
            exp_v = q_lo.pop_front();
            act_v = {bus_lo.o_y, bus_lo.o_valid, bus_lo.o_err};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL lo_out t=%0t: got y=%b v=%b e=%b, expected y=%b v=%b e=%b",
                         $time, act_v[5:2], act_v[1], act_v[0], exp_v[5:2], exp_v[1], exp_v[0]);
            end
        end
    end

    // Present one vector ahead of the next rising edge and queue its result.
    task automatic drive(input logic r, input logic en, input logic [9:0] din,
                         input logic [3:0] y_hi, input logic [3:0] y_lo,
                         input logic v, input logic e);
        @(negedge clk);
        rst         = r;
        bus_hi.i_en = en;
        bus_lo.i_en = en;
        bus_hi.i_i  = din;
        bus_lo.i_i  = din;
        q_hi.push_back({y_hi, v, e});
        q_lo.push_back({y_lo, v, e});
        @(posedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst         = 1'b1;
        bus_hi.i_en = 1'b0;
        bus_lo.i_en = 1'b0;
        bus_hi.i_i  = 10'd0;
        bus_lo.i_i  = 10'd0;

        // Reset held two cycles with an enabled, valid-looking input
        drive(1'b1, 1'b1, 10'h200, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 10'h200, 4'd0, 4'd0, 1'b0, 1'b0);

        // Enable off: walking one-hot input is ignored
        for (int k = 0; k < 10; k++)
            drive(1'b0, 1'b0, 10'(1 << k), 4'd0, 4'd0, 1'b0, 1'b0);

        // One-hot walk, back-to-back
        for (int k = 0; k < 10; k++)
            drive(1'b0, 1'b1, 10'(1 << k), 4'(k), 4'(k), 1'b1, 1'b0);

        // Multi-hot: lines 7 and 2
        drive(1'b0, 1'b1, 10'b0010000100, 4'd7, 4'd2, 1'b1, 1'b1);
        // Multi-hot: all lines
        drive(1'b0, 1'b1, 10'h3FF, 4'd9, 4'd0, 1'b1, 1'b1);
        // Multi-hot: lines 9 and 8
        drive(1'b0, 1'b1, 10'h300, 4'd9, 4'd8, 1'b1, 1'b1);

        // Zero input, then a clean digit 3
        drive(1'b0, 1'b1, 10'h000, 4'd0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 10'h008, 4'd3, 4'd3, 1'b1, 1'b0);

        // Enable toggling between adjacent samples
        drive(1'b0, 1'b0, 10'h010, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 10'h010, 4'd4, 4'd4, 1'b1, 1'b0);

        // Reset mid-walk at k=5, release at k=6
        for (int k = 0; k < 5; k++)
            drive(1'b0, 1'b1, 10'(1 << k), 4'(k), 4'(k), 1'b1, 1'b0);
        drive(1'b1, 1'b1, 10'h020, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 10'h040, 4'd6, 4'd6, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 10'h080, 4'd7, 4'd7, 1'b1, 1'b0);

        // Drain: every queued expectation must have been consumed
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (q_hi.size() != 0 || q_lo.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d entries left, expected 0/0", q_hi.size(), q_lo.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
